// File: rtl/dmi_dr_engine.sv
// dmi_dr_engine: parametrised DMI data register with posted request queue; optional response timeout via DMI_TIMEOUT_EN
module dmi_dr_engine #(
  parameter int AbitsW        = 7,
  parameter int DataW         = 32,
  parameter int QDepth        = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        test_logic_reset_i,
  input  logic                        capture_dr_i,
  input  logic                        shift_dr_i,
  input  logic                        update_dr_i,
  input  logic                        dmi_access_i,
  input  logic                        dtmcs_select_i,
  input  logic                        dmi_reset_i,
  input  logic                        dmi_tdi_i,
  output logic                        dmi_tdo_o,
  output logic [1:0]                  error_o,
  output logic [AbitsW+DataW+1:0]     req_o,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  input  logic [DataW+1:0]            resp_i,
  input  logic                        resp_valid_i,
  output logic                        resp_ready_o
);
  localparam int DrW = AbitsW + DataW + 2;
  localparam int PW  = QDepth > 1 ? $clog2(QDepth) : 1;
  localparam int CW  = $clog2(QDepth + 1);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e            state_q, state_d;
  logic [DrW-1:0]    dr_q;
  logic [DrW-1:0]    mem_q [QDepth];
  logic [PW-1:0]     rptr_q, wptr_q, rnxt, wnxt;
  logic [CW-1:0]     cnt_q;
  logic [AbitsW-1:0] addr_q;
  logic [DataW-1:0]  data_q;
  logic [1:0]        error_q, error_d, st;
  logic              rd_q, rd_fl_q;
  logic              cap, shf, upd, push, pop, full, empty, resp_fire, flush, busy, tmo;
`ifdef DMI_TIMEOUT_EN
  localparam int TW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
  logic [TW-1:0] tmo_q;
  assign tmo = (state_q == WAIT) & ~resp_valid_i & (tmo_q == TW'(TimeoutCycles - 1));
  // response timeout counter, cleared on each issue
  always_ff @(posedge clk_i) begin
    if (rst_i) tmo_q <= '0;
    else tmo_q <= pop ? '0 : (state_q == WAIT) ? tmo_q + TW'(1) : tmo_q;
  end
`else
  logic unused_timeout;
  assign tmo = 1'b0;
  assign unused_timeout = TimeoutCycles > 0;
`endif
  assign dmi_tdo_o    = dr_q[0];
  assign error_o      = error_q;
  assign req_o        = mem_q[rptr_q];
  assign req_valid_o  = (state_q == IDLE) & ~empty;
  assign resp_ready_o = state_q == WAIT;
  // strobe decode, queue status from registered state, error priority (clear > busy > failed)
  always_comb begin
    cap       = capture_dr_i & dmi_access_i;
    shf       = shift_dr_i & dmi_access_i;
    full      = cnt_q == CW'(QDepth);
    empty     = cnt_q == '0;
    upd       = update_dr_i & dmi_access_i & (error_q == 2'd0) & (dr_q[1] ^ dr_q[0]);
    push      = upd & ~full & ~rd_q;
    pop       = (state_q == IDLE) & ~empty & req_ready_i;
    resp_fire = (state_q == WAIT) & resp_valid_i;
    flush     = resp_fire & (resp_i[1:0] != 2'd0) | tmo;
    busy      = upd & (full | rd_q) | cap & rd_q;
    error_d   = (dmi_reset_i & dtmcs_select_i) ? 2'd0 : busy ? 2'd3 : (flush & error_q != 2'd3) ? 2'd2 : error_q;
    st        = (error_q == 2'd3 | rd_q) ? 2'd3 : error_q;
    rnxt      = rptr_q == PW'(QDepth - 1) ? '0 : rptr_q + PW'(1);
    wnxt      = wptr_q == PW'(QDepth - 1) ? '0 : wptr_q + PW'(1);
    state_d   = pop ? WAIT : (resp_fire | tmo) ? IDLE : state_q;
  end
  // data register: capture, shift; Test-Logic-Reset clears only this
  always_ff @(posedge clk_i) begin
    if (rst_i || test_logic_reset_i) dr_q <= '0;
    else if (cap) dr_q <= {addr_q, data_q, st};
    else if (shf) dr_q <= {dmi_tdi_i, dr_q[DrW-1:1]};
  end
  // posted request queue; a failed response or timeout drops everything queued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < QDepth; i++) mem_q[i] <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= dr_q;
      wptr_q <= push ? wnxt : wptr_q;
      rptr_q <= pop ? rnxt : rptr_q;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  // issue FSM, read-pending tracking, sticky error and last addr/data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      rd_fl_q <= 1'b0;
      error_q <= 2'd0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      rd_q    <= ~(flush | resp_fire & rd_fl_q) & (rd_q | push & (dr_q[1:0] == 2'd1));
      rd_fl_q <= pop ? (req_o[1:0] == 2'd1) : rd_fl_q;
      addr_q  <= push ? dr_q[DrW-1:DataW+2] : addr_q;
      data_q  <= push ? dr_q[DataW+1:2] : (resp_fire & rd_fl_q) ? resp_i[DataW+1:2] : data_q;
    end
  end
endmodule

// File: tb/tb_dmi_dr_engine.sv
// tb_dmi_dr_engine: directed bench with a queue-based reference model checked every cycle
module tb_dmi_dr_engine;
  localparam int AW = 7, DW = 32, QD = 2, TO = 8, DRW = AW + DW + 2;
  logic clk = 0, rst_i = 1, tlr = 0, cap = 0, shf = 0, upd = 0, acc = 1, dsel = 0, dres = 0, tdi = 0;
  logic tdo, req_valid_o, resp_ready_o, req_ready_i = 0, resp_valid_i = 0;
  logic [1:0] error_o;
  logic [DRW-1:0] req_o, g;
  logic [DW+1:0] resp_i = '0;
  int n_chk = 0, n_fail = 0;

  dmi_dr_engine #(.AbitsW(AW), .DataW(DW), .QDepth(QD), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .test_logic_reset_i(tlr), .capture_dr_i(cap), .shift_dr_i(shf),
    .update_dr_i(upd), .dmi_access_i(acc), .dtmcs_select_i(dsel), .dmi_reset_i(dres), .dmi_tdi_i(tdi),
    .dmi_tdo_o(tdo), .error_o(error_o), .req_o(req_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .resp_i(resp_i), .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o));

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // reference model: pending requests as a queue, outstanding request as a flag
  logic [DRW-1:0] m_q[$];
  bit m_wait, m_rdfl;
  logic [1:0] m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DRW-1:0] m_dr;
  int m_wcnt;

  always @(posedge clk) begin : model
    bit rdp, full, up, push, blk, rf, fail, tmo, pf;
    logic [1:0] op, nerr;
    logic [DRW-1:0] odr;
    if (rst_i) begin
      m_q.delete(); m_wait = 0; m_rdfl = 0; m_err = 0; m_addr = 0; m_data = 0; m_dr = 0; m_wcnt = 0;
    end else begin
      odr = m_dr;
      rdp = m_wait && m_rdfl;
      foreach (m_q[i]) if (m_q[i][1:0] == 2'd1) rdp = 1;
      full = m_q.size() == QD;
      op = odr[1:0];
      up = upd && acc && m_err == 0 && (op == 2'd1 || op == 2'd2);
      push = up && !full && !rdp;
      blk = up && !push;
      rf = m_wait && resp_valid_i;
      fail = rf && resp_i[1:0] != 2'd0;
      tmo = 0;
`ifdef DMI_TIMEOUT_EN
      if (m_wait && !resp_valid_i) begin
        if (m_wcnt == TO - 1) tmo = 1;
        else m_wcnt++;
      end
`endif
      pf = !m_wait && m_q.size() > 0 && req_ready_i;
      nerr = m_err;
      if ((fail || tmo) && m_err != 2'd3) nerr = 2'd2;
      if (blk || (cap && acc && rdp)) nerr = 2'd3;
      if (dres && dsel) nerr = 2'd0;
      if (tlr) m_dr = 0;
      else if (cap && acc) m_dr = {m_addr, m_data, (rdp || m_err == 2'd3) ? 2'd3 : m_err};
      else if (shf && acc) m_dr = {tdi, odr[DRW-1:1]};
      if (push) begin m_addr = odr[DRW-1:DW+2]; m_data = odr[DW+1:2]; end
      if (rf && m_rdfl) m_data = resp_i[DW+1:2];
      if (pf) begin
        m_rdfl = m_q[0][1:0] == 2'd1;
        void'(m_q.pop_front());
        m_wait = 1;
        m_wcnt = 0;
      end else if (rf || tmo) m_wait = 0;
      if (push) m_q.push_back(odr);
      if (fail || tmo) m_q.delete();
      m_err = nerr;
    end
  end

  always @(negedge clk) if (!rst_i) begin
    chk("error_o", error_o, m_err);
    chk("req_valid_o", req_valid_o, !m_wait && m_q.size() > 0);
    chk("resp_ready_o", resp_ready_o, m_wait);
    chk("dmi_tdo_o", tdo, m_dr[0]);
    if (req_valid_o && m_q.size() > 0) chk("req_o", req_o, m_q[0]);
  end

  task automatic dmi_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] op, output logic [DRW-1:0] got);
    logic [DRW-1:0] v;
    v = {a, d, op};
    cap = 1;
    @(negedge clk);
    cap = 0;
    shf = 1;
    for (int i = 0; i < DRW; i++) begin
      tdi = v[i];
      got[i] = tdo;
      @(negedge clk);
    end
    shf = 0;
    upd = 1;
    @(negedge clk);
    upd = 0;
  endtask

  task automatic accept(input logic [DRW-1:0] exp, input string nm);
    int n = 0;
    while (!req_valid_o && n < 100) begin @(negedge clk); n++; end
    chk({nm, " valid"}, req_valid_o, 1);
    chk(nm, req_o, exp);
    req_ready_i = 1;
    @(negedge clk);
    req_ready_i = 0;
  endtask

  task automatic respond(input logic [DW-1:0] d, input logic [1:0] c);
    int n = 0;
    while (!resp_ready_o && n < 100) begin @(negedge clk); n++; end
    chk("resp_ready wait", resp_ready_o, 1);
    resp_valid_i = 1;
    resp_i = {d, c};
    @(negedge clk);
    resp_valid_i = 0;
    resp_i = '0;
  endtask

  task automatic clr_err();
    dres = 1;
    dsel = 1;
    @(negedge clk);
    dres = 0;
    dsel = 0;
    chk("error cleared", error_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset tdo", tdo, 0);
    chk("reset error", error_o, 0);
    chk("reset req_valid", req_valid_o, 0);
    chk("reset resp_ready", resp_ready_o, 0);
    chk("reset req_o", req_o, 0);
    rst_i = 0;
    @(negedge clk);
    dmi_op(7'h10, 32'hDEADBEEF, 2'd2, g);
    accept({7'h10, 32'hDEADBEEF, 2'd2}, "write req");
    respond(32'h0, 2'd0);
    dmi_op(7'h10, 32'h0, 2'd1, g);
    chk("capture after write", g, {7'h10, 32'hDEADBEEF, 2'd0});
    accept({7'h10, 32'h0, 2'd1}, "read req");
    respond(32'hDEADBEEF, 2'd0);
    dmi_op(7'h0, 32'h0, 2'd0, g);
    chk("read capture", g, {7'h10, 32'hDEADBEEF, 2'd0});
    dmi_op(7'h01, 32'h11, 2'd2, g);
    dmi_op(7'h02, 32'h22, 2'd2, g);
    chk("posted no error", error_o, 0);
    dmi_op(7'h03, 32'h33, 2'd2, g);
    chk("third write busy", error_o, 3);
    cap = 1;
    @(negedge clk);
    cap = 0;
    chk("busy status tdo", tdo, 1);
    tlr = 1;
    @(negedge clk);
    tlr = 0;
    chk("tlr clears dr", tdo, 0);
    chk("tlr keeps error", error_o, 3);
    clr_err();
    accept({7'h01, 32'h11, 2'd2}, "posted 1");
    respond(32'h0, 2'd0);
    accept({7'h02, 32'h22, 2'd2}, "posted 2");
    respond(32'h0, 2'd0);
    repeat (5) @(negedge clk);
    chk("only two issued", req_valid_o, 0);
    dmi_op(7'h05, 32'h0, 2'd1, g);
    accept({7'h05, 32'h0, 2'd1}, "read 5");
    dmi_op(7'h0, 32'h0, 2'd0, g);
    chk("pending status", g[1:0], 3);
    chk("pending error", error_o, 3);
    clr_err();
    respond(32'h1234, 2'd0);
    dmi_op(7'h0, 32'h0, 2'd0, g);
    chk("read 5 data", g, {7'h05, 32'h1234, 2'd0});
    dmi_op(7'h06, 32'hAA, 2'd2, g);
    dmi_op(7'h07, 32'hBB, 2'd2, g);
    accept({7'h06, 32'hAA, 2'd2}, "write 6");
    respond(32'h0, 2'd2);
    chk("failed error", error_o, 2);
    chk("flushed valid", req_valid_o, 0);
    repeat (3) @(negedge clk);
    chk("flushed stays empty", req_valid_o, 0);
    clr_err();
    dmi_op(7'h08, 32'h0, 2'd1, g);
    accept({7'h08, 32'h0, 2'd1}, "read 8");
`ifdef DMI_TIMEOUT_EN
    n = 0;
    while (error_o != 2'd2 && n < 50) begin @(negedge clk); n++; end
    chk("timeout cycles", n, TO);
    chk("timeout resp_ready", resp_ready_o, 0);
    chk("timeout idle", req_valid_o, 0);
    clr_err();
`else
    n = 0;
    repeat (1000) @(negedge clk);
    chk("still waiting", resp_ready_o, 1);
    chk("no timeout error", error_o, 0);
    respond(32'h55, 2'd0);
`endif
    dmi_op(7'h09, 32'h99, 2'd2, g);
    accept({7'h09, 32'h99, 2'd2}, "write 9");
    chk("in wait", resp_ready_o, 1);
    rst_i = 1;
    @(negedge clk);
    chk("rst resp_ready", resp_ready_o, 0);
    chk("rst req_valid", req_valid_o, 0);
    chk("rst error", error_o, 0);
    chk("rst req_o", req_o, 0);
    chk("rst tdo", tdo, 0);
    rst_i = 0;
    @(negedge clk);
    dmi_op(7'h0A, 32'h0, 2'd0, g);
    chk("capture after rst", g, 0);
    dmi_op(7'h0B, 32'hCAFE, 2'd2, g);
    accept({7'h0B, 32'hCAFE, 2'd2}, "write B");
    respond(32'h0, 2'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
